pipeline_hazard_ctrl: RTL

//  Pipeline sequencing controller for the 5-stage MIPS core; works alongside the EX-stage forwarding unit.
//  - Detects load-use hazards that forwarding cannot cover.
//  - Squashes wrong-path instructions on a taken branch.
//  - Schedules the shared multi-cycle MULT/DIV unit (MDU), stalling ID while HI/LO is in flight.
//  - Drives PC/IFID write enables and the IDEX bubble.

---
 rtl/mips_ctrl_pkg.sv | 14 +
 rtl/mdu_busy_timer.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings and defaults for the MIPS pipeline sequencing control.
package mips_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_t;

  localparam int MDU_MULT_CYCLES = 4;
  localparam int MDU_DIV_CYCLES  = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mdu_busy_timer.sv
// Loadable down-counter tracking the remaining MDU busy cycles; done flags the last busy cycle.
module mdu_busy_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_run,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = i_run && (r_cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / taken-branch / MDU hazard control for the 5-stage MIPS pipeline.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IDEXmemRead,
  input  logic [4:0]  IDEXregisterRt,
  input  logic [4:0]  IFIDrs,
  input  logic [4:0]  IFIDrt,
  input  logic        IDmduOp,
  input  logic        IDmduDiv,
  input  logic        IDreadsHiLo,
  input  logic        EXbranchTaken,
  output logic        pcWrite,
  output logic        IFIDwrite,
  output logic        IFIDflush,
  output logic        IDEXbubble,
  output logic        mduStart,
  output logic        mduBusy,
  output logic        mduDone,
  output logic [31:0] stallCount,
  output logic [31:0] flushCount
);

  localparam logic [CNT_W-1:0] LP_MULT_LD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_DIV_LD  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_t r_state;
  mdu_state_t w_state_nxt;
  logic       w_load_use;
  logic       w_mdu_haz;
  logic       w_stall;
  logic       w_flush;
  logic       w_issue;
  logic       w_busy;
  logic       w_done;

  assign w_busy     = (r_state == ST_BUSY);
  assign w_load_use = IDEXmemRead && (IDEXregisterRt != REG_ZERO) &&
                      ((IDEXregisterRt == IFIDrs) || (IDEXregisterRt == IFIDrt));
  assign w_mdu_haz  = w_busy && (IDmduOp || IDreadsHiLo);
  assign w_flush    = EXbranchTaken;
  assign w_stall    = (w_load_use || w_mdu_haz) && !w_flush;
  // Gated by rst so a held reset can never load the timer or leave IDLE.
  assign w_issue    = rst && IDmduOp && !w_busy && !w_load_use && !w_flush;

  mdu_busy_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_issue),
    .i_load_val (IDmduDiv ? LP_DIV_LD : LP_MULT_LD),
    .i_run      (w_busy),
    .o_done     (w_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_issue) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_done)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  assign pcWrite    = rst && !w_stall;
  assign IFIDwrite  = rst && !w_stall;
  assign IFIDflush  = !rst || w_flush;
  assign IDEXbubble = !rst || w_stall || w_flush;
  assign mduStart   = w_issue;
  assign mduBusy    = rst && w_busy;
  assign mduDone    = rst && w_done;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stallCount = r_stall_cnt;
  assign flushCount = r_flush_cnt;
`else
  assign stallCount = 32'd0;
  assign flushCount = 32'd0;
`endif

endmodule
